regfile_writeback_ctrl: RTL
===========================

// Module: regfile_writeback_ctrl
// PURPOSE
//  Write side of the 32x32 integer register file: merges ALU results and load responses into its single write port.
//  Buffers loads in a small FIFO and arbitrates with an anti-starvation limit.
//  Keeps a pending-write scoreboard so decode can stall on RAW hazards.
//  Sits between execute/data-memory return and the register file write inputs.
// PARAMETERS
//  LD_FIFO_DEPTH  4  load-response buffer entries; power of 2, >= 2
//  STARVE_LIMIT   8  consecutive ALU wins with a non-empty FIFO before ALU is back-pressured; >= 1
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   synchronous, active-high reset
//  alu_valid     in   1   ALU result present
//  alu_ready     out  1   ALU result accepted this cycle (alu_valid & alu_ready)
//  alu_rd        in   5   ALU destination register
//  alu_data      in   32  ALU result
//  ld_valid      in   1   load response present
//  ld_ready      out  1   load accepted this cycle
//  ld_rd         in   5   load destination register
//  ld_data       in   32  load data
//  issue_valid   in   1   instruction with destination issued
//  issue_rd      in   5   its destination register
//  query_rs1     in   5   decode source 1
//  query_rs2     in   5   decode source 2
//  rs1_busy      out  1   query_rs1 has pending write (comb. from scoreboard)
//  rs2_busy      out  1   query_rs2 has pending write
//  write_enable  out  1   to register file, registered
//  write_addr    out  5   to register file, registered
//  write_data    out  32  to register file, registered
//  ld_count      out  $clog2(LD_FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: write_enable/addr/data=0, FIFO empty, ld_count=0, scoreboard all 0, starve counter 0; ld_ready=1, alu_ready=1 the cycle after.
//  ld_ready = FIFO not full. alu_ready = (starve_cnt != STARVE_LIMIT). Both are combinational from state only, not from valids.
//  Per cycle, exactly one winner, write driven next cycle (1-cycle latency):
//   1) FIFO non-empty and starve_cnt==STARVE_LIMIT: pop head; ALU not accepted.
//   2) alu_valid & alu_ready: ALU wins; an accepted load is pushed to the FIFO.
//   3) FIFO non-empty: pop head; an accepted load is pushed (push+pop when full is impossible, ld_ready=0).
//   4) FIFO empty & accepted load: bypass direct to write port, no push.
//   5) none: write_enable=0 next cycle.
//  starve_cnt: +1 when the ALU wins with FIFO non-empty after the push; clears on any pop and when the FIFO is empty.
//  Winner rd==0: consumed, write_enable stays 0, no scoreboard clear.
//  Scoreboard pending[31:1]:
//   - set by issue_valid on issue_rd;
//   - cleared by the cycle write_enable=1 on write_addr.
//   - Same-cycle set+clear of one register: set wins. pending[0] is constant 0.
//  Load order within the FIFO is preserved. No ordering across the ALU and load sources; the pipeline guarantees one pending writer per rd.
//  rst mid-operation drops FIFO contents and in-flight write; no write_enable the cycle after reset.
// CONFIGURATION
//  REGFILE_WB_FORWARD_EN defined: adds outputs fwd1_valid/fwd2_valid (1) and fwd1_data/fwd2_data (32).
//   - While write_enable=1 and write_addr==query_rsN!=0: fwd_valid=1, fwd_data=write_data, rsN_busy forced 0.
//  Undefined: no forward ports; rsN_busy reflects the scoreboard only, so decode waits one extra cycle after the write.
// STRUCTURE
//  Package rv_wb_pkg:
//   - XLEN=32, REG_ADDR_W=5;
//   - typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_req_t;
//   - enum of winner select {WB_NONE, WB_ALU, WB_FIFO, WB_BYPASS}.
//  Sub-module wb_sync_fifo #(DEPTH, wb_req_t):
//   - ptr+1-bit full/empty, push/pop/count, same clk/rst.
//  Top holds the arbiter, starve counter, scoreboard and output registers.
// TESTING
//  1 Reset then ALU rd=5 data=0xDEADBEEF -> next cycle we=1 addr=5 data=0xDEADBEEF; ld_count=0.
//  2 ALU valid every cycle and 9 loads rd=1..9 -> FIFO fills to 4, ld_ready=0;
//    after 8 ALU wins alu_ready=0 and FIFO head rd=1 written; loads emerge in order.
//  3 FIFO empty, no ALU, load rd=7 data=0x55 -> we next cycle addr=7 data=0x55, ld_count stays 0.
//  4 issue rd=3 -> rs1_busy=1 for query_rs1=3; ALU write rd=3 -> busy clears the cycle after we;
//    issue rd=3 in the clearing cycle -> stays 1.
//  5 ALU rd=0 data=0x1 and issue rd=0 -> write_enable stays 0, rs1_busy=0 for query 0.
//  6 Fill FIFO to 3, assert rst one cycle -> ld_count=0, we=0, all busy=0;
//    with FORWARD_EN, we addr=4 & query_rs2=4 -> fwd2_valid=1, rs2_busy=0.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types for the register-file writeback path: request struct and winner select.
package rv_wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_FIFO, WB_BYPASS} wb_sel_e;
endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO for buffered load responses.
// Uses extra-MSB pointers so full and empty can be told apart without a separate counter.
module wb_sync_fifo import rv_wb_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW:0]    wptr_q, rptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write port arbiter (ALU vs buffered loads) with RAW scoreboard.
// Define REGFILE_WB_FORWARD_EN to add write-port forwarding outputs to decode.
module regfile_writeback_ctrl import rv_wb_pkg::*; #(
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [4:0]                     alu_rd,
  input  logic [31:0]                    alu_data,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [4:0]                     ld_rd,
  input  logic [31:0]                    ld_data,
  input  logic                           issue_valid,
  input  logic [4:0]                     issue_rd,
  input  logic [4:0]                     query_rs1,
  input  logic [4:0]                     query_rs2,
  output logic                           rs1_busy,
  output logic                           rs2_busy,
  output logic                           write_enable,
  output logic [4:0]                     write_addr,
  output logic [31:0]                    write_data,
  output logic [$clog2(LD_FIFO_DEPTH):0] ld_count
`ifdef REGFILE_WB_FORWARD_EN
  ,
  output logic                           fwd1_valid,
  output logic                           fwd2_valid,
  output logic [31:0]                    fwd1_data,
  output logic [31:0]                    fwd2_data
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic          fifo_full, fifo_empty, push, pop, ld_acc;
  wb_req_t       head, ld_req, alu_req, win_req;
  wb_sel_e       sel;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pending_q, pending_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;

  assign ld_req  = '{rd: ld_rd,  data: ld_data};
  assign alu_req = '{rd: alu_rd, data: alu_data};

  wb_sync_fifo #(.DEPTH(LD_FIFO_DEPTH), .T(wb_req_t)) u_ld_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ld_req),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (ld_count)
  );

  assign ld_ready  = !fifo_full;
  assign alu_ready = (starve_q != STARVE_MAX);
  assign ld_acc    = ld_valid && ld_ready;

  always_comb begin
    sel  = WB_NONE;
    push = 1'b0;
    pop  = 1'b0;
    // A saturated starve counter means alu_ready is already low, so the FIFO drains first.
    if (!fifo_empty && !alu_ready) begin
      sel = WB_FIFO; pop = 1'b1; push = ld_acc;
    end else if (alu_valid && alu_ready) begin
      sel = WB_ALU; push = ld_acc;
    end else if (!fifo_empty) begin
      sel = WB_FIFO; pop = 1'b1; push = ld_acc;
    end else if (ld_acc) begin
      sel = WB_BYPASS;
    end

    unique case (sel)
      WB_ALU:    win_req = alu_req;
      WB_FIFO:   win_req = head;
      WB_BYPASS: win_req = ld_req;
      default:   win_req = '0;
    endcase

    if (pop || (fifo_empty && !push)) starve_d = '0;
    else if (sel == WB_ALU)           starve_d = starve_q + SW'(1);
    else                              starve_d = starve_q;

    // rd==0 winners are consumed silently: no write, no scoreboard effect.
    we_d   = (sel != WB_NONE) && (win_req.rd != '0);
    addr_d = (sel != WB_NONE) ? win_req.rd   : addr_q;
    data_d = (sel != WB_NONE) ? win_req.data : data_q;

    pending_d = pending_q;
    if (we_q)        pending_d[addr_q]   = 1'b0;
    if (issue_valid) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      pending_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;

`ifdef REGFILE_WB_FORWARD_EN
  assign fwd1_valid = we_q && (addr_q == query_rs1) && (query_rs1 != '0);
  assign fwd2_valid = we_q && (addr_q == query_rs2) && (query_rs2 != '0);
  assign fwd1_data  = data_q;
  assign fwd2_data  = data_q;
  assign rs1_busy   = pending_q[query_rs1] && !fwd1_valid;
  assign rs2_busy   = pending_q[query_rs2] && !fwd2_valid;
`else
  assign rs1_busy   = pending_q[query_rs1];
  assign rs2_busy   = pending_q[query_rs2];
`endif
endmodule
